// File: rtl/buf_pkg.sv
// -----------------------------------------------------------------------------
// buf_pkg
// Shared definitions for the packet-buffer blocks (page allocator, page-chain
// builder, egress release logic).
//   BUF_NUM_PAGES : default number of buffer pages
//   BUF_PAGE_W    : width of a page id for the default page count
//   page_id_t     : page identifier
//   page_cnt_t    : page count, one bit wider than a page id so it can hold
//                   the full page count
// -----------------------------------------------------------------------------
package buf_pkg;

   localparam int BUF_NUM_PAGES = 64;
   localparam int BUF_PAGE_W    = $clog2(BUF_NUM_PAGES);

   typedef logic [BUF_PAGE_W-1:0] page_id_t;
   typedef logic [BUF_PAGE_W:0]   page_cnt_t;

endpackage

// File: rtl/lzc.sv
// -----------------------------------------------------------------------------
// lzc
// Zero counter over a WIDTH-bit vector.
//   MODE = 0 : trailing mode, cnt is the index of the lowest set bit
//   MODE = 1 : leading mode, cnt is the number of zeros above the highest set bit
// Ports:
//   data  : input vector
//   cnt   : zero count (0 when data is all zeros)
//   empty : high when no bit of data is set
// -----------------------------------------------------------------------------
module lzc #(
   parameter int WIDTH = 64,
   parameter int MODE  = 0,
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt,
   output logic             empty
);

   // Scan so that the last hit wins: top-down in trailing mode leaves the
   // lowest set index, bottom-up in leading mode leaves the highest one.
   always_comb begin
      cnt   = '0;
      empty = 1'b1;
      if (MODE == 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data[i]) begin
               cnt   = CNT_W'(i);
               empty = 1'b0;
            end
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
               cnt   = CNT_W'(WIDTH - 1 - i);
               empty = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/page_alloc.sv
// -----------------------------------------------------------------------------
// page_alloc
// Free-page allocator for the shared packet buffer. A free bitmap is searched
// for its lowest free page, which is pre-staged in an output register so one
// page can be handed out per cycle. Released pages come back on the free port.
// Ports:
//   clk_i             : clock
//   rst_ni            : asynchronous active-low reset
//   alloc_valid_o     : a staged page is available
//   alloc_ready_i     : consumer takes the staged page this cycle
//   alloc_id_o        : staged page id
//   free_valid_i      : return a page (always accepted)
//   free_id_i         : page being returned
//   free_cnt_o        : pages not handed out (bitmap plus staged page)
//   empty_o           : free_cnt_o == 0
//   err_double_free_o : sticky, a free hit a page that was not handed out
//   err_range_o       : sticky, a free carried an id >= NUM_PAGES
// -----------------------------------------------------------------------------
module page_alloc
   import buf_pkg::*;
#(
   parameter int NUM_PAGES = BUF_NUM_PAGES,
   parameter int PAGE_W    = $clog2(NUM_PAGES)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic              alloc_valid_o,
   input  logic              alloc_ready_i,
   output logic [PAGE_W-1:0] alloc_id_o,
   input  logic              free_valid_i,
   input  logic [PAGE_W-1:0] free_id_i,
   output logic [PAGE_W:0]   free_cnt_o,
   output logic              empty_o,
   output logic              err_double_free_o,
   output logic              err_range_o
);

   logic [NUM_PAGES-1:0] free_q, free_d;
   logic                 stg_valid_q, stg_valid_d;
   logic [PAGE_W-1:0]    stg_id_q, stg_id_d;
   logic [PAGE_W:0]      cnt_q, cnt_d;
   logic                 err_df_q, err_df_d;
   logic                 err_rng_q, err_rng_d;

   logic [PAGE_W-1:0]    lzc_cnt;
   logic                 lzc_empty;

   logic                 transfer;
   logic                 refill;
   logic                 in_range;
   logic                 hits_stage;
   logic                 bit_set;
   logic                 free_legal;

   // Lowest free page of the registered bitmap.
   lzc #(
      .WIDTH (NUM_PAGES),
      .MODE  (0)
   ) u_lzc (
      .data  (free_q),
      .cnt   (lzc_cnt),
      .empty (lzc_empty)
   );

   // A returned page is legal only when it is currently held by the consumer:
   // in range, not sitting in the bitmap, and not the page still staged here.
   always_comb begin
      transfer   = stg_valid_q & alloc_ready_i;
      refill     = ~stg_valid_q | transfer;
      in_range   = 32'(free_id_i) < 32'(NUM_PAGES);
      bit_set    = in_range & free_q[free_id_i];
      hits_stage = stg_valid_q & (stg_id_q == free_id_i);
      free_legal = free_valid_i & in_range & ~bit_set & ~hits_stage;
   end

   // Next-state logic. The refill always works from the pre-update bitmap, so
   // a page freed in the same cycle only becomes visible to the search on the
   // next cycle; the two bitmap updates can never touch the same bit.
   always_comb begin
      free_d      = free_q;
      stg_valid_d = stg_valid_q;
      stg_id_d    = stg_id_q;
      cnt_d       = cnt_q;
      err_df_d    = err_df_q;
      err_rng_d   = err_rng_q;

      if (refill) begin
         if (!lzc_empty) begin
            stg_valid_d      = 1'b1;
            stg_id_d         = lzc_cnt;
            free_d[lzc_cnt]  = 1'b0;
         end else begin
            stg_valid_d = 1'b0;
         end
      end

      if (free_legal) begin
         free_d[free_id_i] = 1'b1;
      end

      if (free_valid_i && !in_range) begin
         err_rng_d = 1'b1;
      end
      if (free_valid_i && in_range && (bit_set || hits_stage)) begin
         err_df_d = 1'b1;
      end

      if (transfer && !free_legal) begin
         cnt_d = cnt_q - (PAGE_W+1)'(1);
      end else if (free_legal && !transfer) begin
         cnt_d = cnt_q + (PAGE_W+1)'(1);
      end
   end

   // State register: every page free, nothing staged, no errors on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         free_q      <= '1;
         stg_valid_q <= 1'b0;
         stg_id_q    <= '0;
         cnt_q       <= (PAGE_W+1)'(NUM_PAGES);
         err_df_q    <= 1'b0;
         err_rng_q   <= 1'b0;
      end else begin
         free_q      <= free_d;
         stg_valid_q <= stg_valid_d;
         stg_id_q    <= stg_id_d;
         cnt_q       <= cnt_d;
         err_df_q    <= err_df_d;
         err_rng_q   <= err_rng_d;
      end
   end

   assign alloc_valid_o     = stg_valid_q;
   assign alloc_id_o        = stg_id_q;
   assign free_cnt_o        = cnt_q;
   assign empty_o           = (cnt_q == '0);
   assign err_double_free_o = err_df_q;
   assign err_range_o       = err_rng_q;

endmodule

// File: tb/tb_page_alloc.sv
// -----------------------------------------------------------------------------
// tb_page_alloc
// Self-checking bench for page_alloc. Three instances (64, 48 and 5 pages)
// share clock and reset. Directed steps cover reset, streaming, free-to-grant
// latency, error flags and mid-stream reset; a randomized phase on the 64-page
// instance is checked against a model that tracks which pages the consumer
// holds.
// -----------------------------------------------------------------------------
module tb_page_alloc;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // 64-page instance
   logic       v64, r64, fv64, e64, edf64, er64;
   logic [5:0] id64, fid64;
   logic [6:0] c64;

   // 48-page instance
   logic       v48, r48, fv48, e48, edf48, er48;
   logic [5:0] id48, fid48;
   logic [6:0] c48;

   // 5-page instance
   logic       v5, r5, fv5, e5, edf5, er5;
   logic [2:0] id5, fid5;
   logic [3:0] c5;

   page_alloc #(.NUM_PAGES(64)) u_dut64 (
      .clk_i(clk), .rst_ni(rst_n),
      .alloc_valid_o(v64), .alloc_ready_i(r64), .alloc_id_o(id64),
      .free_valid_i(fv64), .free_id_i(fid64), .free_cnt_o(c64),
      .empty_o(e64), .err_double_free_o(edf64), .err_range_o(er64)
   );

   page_alloc #(.NUM_PAGES(48)) u_dut48 (
      .clk_i(clk), .rst_ni(rst_n),
      .alloc_valid_o(v48), .alloc_ready_i(r48), .alloc_id_o(id48),
      .free_valid_i(fv48), .free_id_i(fid48), .free_cnt_o(c48),
      .empty_o(e48), .err_double_free_o(edf48), .err_range_o(er48)
   );

   page_alloc #(.NUM_PAGES(5)) u_dut5 (
      .clk_i(clk), .rst_ni(rst_n),
      .alloc_valid_o(v5), .alloc_ready_i(r5), .alloc_id_o(id5),
      .free_valid_i(fv5), .free_id_i(fid5), .free_cnt_o(c5),
      .empty_o(e5), .err_double_free_o(edf5), .err_range_o(er5)
   );

   // Reference model of the 64-page instance: which pages the consumer holds,
   // plus the page currently offered.
   bit owned [64];
   bit m_valid;
   int m_id;
   bit m_edf;
   int held_q[$];
   int n_owned;
   int lowest;
   bit xfer, legal, refill_now;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and sample just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      r64 = 0; fv64 = 0; fid64 = 0;
      r48 = 0; fv48 = 0; fid48 = 0;
      r5  = 0; fv5  = 0; fid5  = 0;

      // Reset values
      #12;
      check_output("rst_valid", v64, 0);
      check_output("rst_id", id64, 0);
      check_output("rst_cnt", c64, 64);
      check_output("rst_empty", e64, 0);
      check_output("rst_edf", edf64, 0);
      check_output("rst_erange", er64, 0);

      @(negedge clk) rst_n = 1'b1;
      tick();
      check_output("first_valid", v64, 1);
      check_output("first_id", id64, 0);
      check_output("first_cnt", c64, 64);

      // Freeing the staged page 0 is a double free and must be ignored
      fv64 = 1; fid64 = 0;
      tick();
      fv64 = 0;
      check_output("df_stage_flag", edf64, 1);
      check_output("df_stage_cnt", c64, 64);
      check_output("df_stage_id", id64, 0);
      check_output("df_stage_valid", v64, 1);

      // Asynchronous reset clears the flag without a clock edge
      rst_n = 1'b0;
      #2;
      check_output("async_valid", v64, 0);
      check_output("async_edf", edf64, 0);
      check_output("async_cnt", c64, 64);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check_output("rel_id", id64, 0);

      // Stream every page with ready held high
      r64 = 1;
      for (int i = 0; i < 64; i++) begin
         check_output("stream_valid", v64, 1);
         check_output("stream_id", id64, i);
         tick();
      end
      r64 = 0;
      check_output("drained_valid", v64, 0);
      check_output("drained_empty", e64, 1);
      check_output("drained_cnt", c64, 0);

      // Free-to-grant latency from full allocation
      fv64 = 1; fid64 = 17;
      tick();
      fv64 = 0;
      check_output("f17_cnt", c64, 1);
      check_output("f17_valid_early", v64, 0);
      tick();
      check_output("f17_valid", v64, 1);
      check_output("f17_id", id64, 17);
      check_output("f17_cnt2", c64, 1);
      tick();
      check_output("f17_hold_id", id64, 17);
      check_output("f17_hold_valid", v64, 1);
      r64 = 1;
      tick();
      r64 = 0;
      check_output("f17_taken_valid", v64, 0);
      check_output("f17_taken_cnt", c64, 0);

      // Free during a transfer: the refill sees the bitmap before the free,
      // so 11 is offered first and 3 only on the following refill
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      r64 = 1;
      repeat (10) tick();
      check_output("pre_id", id64, 10);
      check_output("pre_cnt", c64, 54);
      fv64 = 1; fid64 = 3;
      tick();
      fv64 = 0;
      check_output("same_cnt", c64, 54);
      check_output("same_id", id64, 11);
      tick();
      check_output("then3_id", id64, 3);
      check_output("then3_cnt", c64, 53);
      tick();
      check_output("then12_id", id64, 12);
      check_output("then12_cnt", c64, 52);

      // Mid-stream reset with 20 pages out and an error flag raised
      repeat (8) tick();
      r64 = 0;
      check_output("out20_cnt", c64, 44);
      check_output("out20_id", id64, 20);
      fv64 = 1; fid64 = 63;
      tick();
      fv64 = 0;
      check_output("df_bitmap_flag", edf64, 1);
      check_output("df_bitmap_cnt", c64, 44);
      rst_n = 1'b0;
      #2;
      check_output("mid_rst_cnt", c64, 64);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check_output("mid_rel_valid", v64, 1);
      check_output("mid_rel_id", id64, 0);
      check_output("mid_rel_cnt", c64, 64);
      check_output("mid_rel_edf", edf64, 0);
      check_output("mid_rel_er", er64, 0);

      // Randomized traffic against the holding model
      foreach (owned[p]) owned[p] = 1'b0;
      m_valid = 1'b1;
      m_id    = 0;
      m_edf   = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r64  = ($urandom_range(0, 3) != 0);
         fv64 = 1'b0;
         fid64 = '0;
         if ($urandom_range(0, 2) == 0) begin
            held_q.delete();
            foreach (owned[p]) if (owned[p]) held_q.push_back(p);
            fv64 = 1'b1;
            if (held_q.size() > 0 && $urandom_range(0, 19) != 0)
               fid64 = 6'(held_q[$urandom_range(0, held_q.size() - 1)]);
            else
               fid64 = 6'($urandom_range(0, 63));
         end
         tick();

         xfer       = m_valid && r64;
         legal      = fv64 && owned[fid64];
         refill_now = !m_valid || xfer;
         if (fv64 && !legal) m_edf = 1'b1;
         lowest = -1;
         for (int p = 0; p < 64; p++) begin
            if (lowest < 0 && !owned[p] && !(m_valid && p == m_id)) lowest = p;
         end
         if (xfer) owned[m_id] = 1'b1;
         if (legal) owned[fid64] = 1'b0;
         if (refill_now) begin
            if (lowest >= 0) begin
               m_valid = 1'b1;
               m_id    = lowest;
            end else begin
               m_valid = 1'b0;
            end
         end
         n_owned = 0;
         foreach (owned[p]) if (owned[p]) n_owned++;

         check_output("rnd_valid", v64, m_valid);
         if (m_valid) check_output("rnd_id", id64, m_id);
         check_output("rnd_cnt", c64, 64 - n_owned);
         check_output("rnd_empty", e64, (n_owned == 64));
         check_output("rnd_edf", edf64, m_edf);
      end
      r64 = 0; fv64 = 0;

      // Out-of-range free on the 48-page instance
      check_output("r48_before", er48, 0);
      fv48 = 1; fid48 = 50;
      tick();
      fv48 = 0;
      check_output("r48_flag", er48, 1);
      check_output("r48_no_df", edf48, 0);
      check_output("r48_cnt", c48, 48);
      check_output("r48_id", id48, 0);
      fv48 = 1; fid48 = 0;
      tick();
      fv48 = 0;
      check_output("r48_df_flag", edf48, 1);
      check_output("r48_df_cnt", c48, 48);

      // Non-power-of-two page count
      r5 = 1;
      for (int i = 0; i < 5; i++) begin
         check_output("p5_valid", v5, 1);
         check_output("p5_id", id5, i);
         tick();
      end
      r5 = 0;
      check_output("p5_drained_valid", v5, 0);
      check_output("p5_drained_empty", e5, 1);
      check_output("p5_drained_cnt", c5, 0);
      fv5 = 1; fid5 = 4;
      tick();
      check_output("p5_f4_cnt", c5, 1);
      check_output("p5_f4_valid", v5, 0);
      fid5 = 1;
      tick();
      fv5 = 0;
      // 4 is staged as soon as it lands since nothing else is waiting
      check_output("p5_f1_cnt", c5, 2);
      check_output("p5_f1_valid", v5, 1);
      check_output("p5_f1_id", id5, 4);
      r5 = 1;
      tick();
      check_output("p5_g1_valid", v5, 1);
      check_output("p5_g1_id", id5, 1);
      check_output("p5_g1_cnt", c5, 1);
      tick();
      r5 = 0;
      check_output("p5_end_valid", v5, 0);
      check_output("p5_end_empty", e5, 1);
      check_output("p5_end_cnt", c5, 0);
      fv5 = 1; fid5 = 6;
      tick();
      fv5 = 0;
      check_output("p5_range_flag", er5, 1);
      check_output("p5_range_cnt", c5, 0);
      check_output("p5_range_no_df", edf5, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
